key_click_decoder: RTL and testbench

- Consumer of the debouncer's single-cycle key-press pulses.
- Classifies each press sequence as a single click or a double click using a programmable time window.
- Emits a one-cycle command pulse per classified event to the second-counter control logic, e.g. single = start/stop and double = clear.
- Includes a post-double lockout so that a third quick press is not re-interpreted as a new click.

---
 rtl/key_click_decoder.sv | 85 ++++++++
 tb/tb_key_click_decoder.sv | 106 ++++++++++
 2 files changed

// File: rtl/key_click_decoder.sv
// rtl/key_click_decoder.sv - single/double click classifier for debounced key pulses
// A press opens a timed window; a second press inside it is a double click, followed by a lockout.
module key_click_decoder #(
  parameter int               CNT_W   = 24,
  parameter logic [CNT_W-1:0] WIN_MAX = 24'd14999999
) (
  input  logic clk,
  input  logic rst,
  input  logic key_pulse,
  output logic single_o,
  output logic double_o,
  output logic busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             single_d, double_d;

  wire win_end = (cnt_q == WIN_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      single_o <= 1'b0;
      double_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_o <= single_d;
      double_o <= double_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_pulse) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // A second press on the last window cycle still counts as a double click.
        if (key_pulse) begin
          double_d = 1'b1;
          state_d  = LOCK;
          cnt_d    = '0;
        end else if (win_end) begin
          single_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOCK: begin
        // Presses are dropped here, including one coinciding with the exit edge.
        if (win_end) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_key_click_decoder.sv
// tb/tb_key_click_decoder.sv - directed bench for key_click_decoder
// Runs with WIN_MAX=15, CNT_W=4; edge numbers are counted from the start of each scenario.
module tb_key_click_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_pulse = 1'b0;
  logic single_o, double_o, busy_o;

  int total = 0;
  int fails = 0;

  key_click_decoder #(
    .CNT_W  (4),
    .WIN_MAX(4'd15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_pulse(key_pulse),
    .single_o (single_o),
    .double_o (double_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int e, input logic act, input logic exp);
    total++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s edge %0d: observed %b expected %b", tag, e, act, exp);
    end
  endtask

  // Pulses p0..p3 (0 = unused), reset held over edges rs..re, single pulses after s0/s1,
  // double pulse after d0, busy after edge e iff e in [b0s,b0e) or [b1s,b1e).
  task automatic run(input string tag, input int n,
                     input int p0, input int p1, input int p2, input int p3,
                     input int rs, input int re,
                     input int s0, input int s1, input int d0,
                     input int b0s, input int b0e, input int b1s, input int b1e);
    for (int e = 1; e <= n; e++) begin
      key_pulse = (e == p0) || (e == p1) || (e == p2) || (e == p3);
      rst = (e >= rs) && (e <= re);
      @(posedge clk);
      #1;
      chk({tag, ".single"}, e, single_o, (e == s0) || (e == s1));
      chk({tag, ".double"}, e, double_o, e == d0);
      chk({tag, ".busy"}, e, busy_o, ((e >= b0s) && (e < b0e)) || ((e >= b1s) && (e < b1e)));
    end
    key_pulse = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    // Reset state while held, with key toggling
    for (int i = 0; i < 4; i++) begin
      key_pulse = i[0];
      @(posedge clk);
      #1;
      chk("rst_hold.single", i, single_o, 1'b0);
      chk("rst_hold.double", i, double_o, 1'b0);
      chk("rst_hold.busy", i, busy_o, 1'b0);
    end
    key_pulse = 1'b0;
    rst = 1'b0;

    // Build up a double click, then assert reset mid-cycle while double_o is high
    key_pulse = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst.busy", 1, busy_o, 1'b1);
    @(posedge clk);
    #1;
    key_pulse = 1'b0;
    chk("pre_rst.double", 2, double_o, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    key_pulse = 1'b1;
    #1;
    chk("async_rst.single", 0, single_o, 1'b0);
    chk("async_rst.double", 0, double_o, 1'b0);
    chk("async_rst.busy", 0, busy_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      key_pulse = ~key_pulse;
    end
    key_pulse = 1'b0;
    rst = 1'b0;
    run("idle100", 100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    run("single", 40, 10, 0, 0, 0, 0, 0, 26, 0, 0, 10, 26, 0, 0);
    run("double", 40, 10, 15, 0, 0, 0, 0, 0, 0, 15, 10, 31, 0, 0);
    run("bound_a", 50, 10, 25, 0, 0, 0, 0, 0, 0, 25, 10, 41, 0, 0);
    run("bound_last", 50, 10, 26, 0, 0, 0, 0, 0, 0, 26, 10, 42, 0, 0);
    run("bound_b", 55, 10, 27, 0, 0, 0, 0, 26, 43, 0, 10, 26, 27, 43);
    run("lockout", 45, 10, 12, 14, 28, 0, 0, 0, 0, 12, 10, 28, 0, 0);
    run("held", 40, 10, 11, 12, 0, 0, 0, 0, 0, 11, 10, 27, 0, 0);
    run("rst_mid", 55, 10, 30, 0, 0, 18, 20, 46, 0, 0, 10, 18, 30, 46);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
